// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder slice.
// Contents: default address/data widths, the wait-state limit, the counter width,
// the FSM state type and the access operation type.
package mem_pkg;

  localparam int unsigned AwDefault = 12;  // 4096 words
  localparam int unsigned DwDefault = 16;
  localparam int unsigned WaitMax   = 7;
  localparam int unsigned CntW      = 3;   // wide enough for WaitMax

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

endpackage

// File: rtl/memory_responder_if.sv
// Request/response bus between memory control (master) and the responder (slave).
//   load/store : request strobes from the master
//   addr/din   : word address and write data
//   dout       : registered read data
//   rdy/busy   : completion pulse and in-flight indication
//   err        : one-cycle error pulse
interface memory_responder_if #(
  parameter int unsigned AW = mem_pkg::AwDefault,
  parameter int unsigned DW = mem_pkg::DwDefault
);
  logic          load;
  logic          store;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          rdy;
  logic          busy;
  logic          err;

  modport master (
    output load, store, addr, din,
    input  dout, rdy, busy, err
  );

  modport slave (
    input  load, store, addr, din,
    output dout, rdy, busy, err
  );
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered read port.
//   clk/rst_n : clock, async active-low reset (clears only the read register)
//   we_i      : write strobe, writes wdata_i to addr_i on the rising edge
//   re_i      : read strobe, loads rdata_o from addr_i on the rising edge
//   rdata_o   : holds the last read word until the next read
// The storage array itself is never reset.
module mem_array #(
  parameter int unsigned AW = 12,
  parameter int unsigned W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Memory responder: accepts one load or store at a time, spends WAIT+1 cycles in
// ACCESS (the array access happens on the last of them) and then pulses rdy for one
// cycle in DONE. Simultaneous load+store in IDLE is rejected with a one-cycle err.
//   clk, rst_n : clock and async active-low reset
//   bus        : memory_responder_if slave (load/store/addr/din in, dout/rdy/busy/err out)
// Parameters: AW address width, DW data width, WAIT wait states (0..7).
// Optional feature: define MEM_PARITY_EN to store an even-parity bit with each word
// and flag a mismatch on err in the rdy cycle of a load.
module memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned AW   = AwDefault,
  parameter int unsigned DW   = DwDefault,
  parameter int unsigned WAIT = 1
) (
  input logic               clk,
  input logic               rst_n,
  memory_responder_if.slave bus
);

  if (WAIT > WaitMax) begin : g_bad_wait
    $error("memory_responder: WAIT must be in 0..7");
  end

`ifdef MEM_PARITY_EN
  localparam int unsigned MW = DW + 1;
`else
  localparam int unsigned MW = DW;
`endif

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  op_e            op_q, op_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  din_q, din_d;
  logic           err_q, err_d;
  logic           we, re;
  logic [MW-1:0]  wdata, rdata;
  logic           par_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    err_d   = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.load && bus.store) begin
          err_d = 1'b1;
        end else if (bus.load || bus.store) begin
          op_d    = bus.store ? OP_WRITE : OP_READ;
          addr_d  = bus.addr;
          din_d   = bus.din;
          cnt_d   = CntW'(WAIT);
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          we      = (op_q == OP_WRITE);
          re      = (op_q == OP_READ);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_PARITY_EN
  assign wdata   = {^din_q, din_q};
  // Stored word carries even parity, so the XOR over all MW bits must be zero.
  assign par_err = (state_q == StDone) && (op_q == OP_READ) && (^rdata);
`else
  assign wdata   = din_q;
  assign par_err = 1'b0;
`endif

  mem_array #(
    .AW (AW),
    .W  (MW)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .re_i    (re),
    .addr_i  (addr_q),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  // The RAM read register only updates on loads, so it doubles as the held dout.
  assign bus.dout = rdata[DW-1:0];
  assign bus.rdy  = (state_q == StDone);
  assign bus.busy = (state_q != StIdle);
  assign bus.err  = err_q | par_err;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: four responders with WAIT = 0, 1, 3, 7 share one request stream;
// each scenario observes the instance selected by sel.
module tb_memory_responder;
  import mem_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
`ifdef MEM_PARITY_EN
  localparam int unsigned MW     = DW + 1;
  localparam logic        ParOn  = 1'b1;
`else
  localparam int unsigned MW     = DW;
  localparam logic        ParOn  = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          load;
  logic          store;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;

  logic [3:0]    rdy_w;
  logic [3:0]    busy_w;
  logic [3:0]    err_w;
  logic [DW-1:0] dout_w [4];

  int checks;
  int errors;
  int sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 7;
    memory_responder_if #(.AW(AW), .DW(DW)) bus ();
    assign bus.load  = load;
    assign bus.store = store;
    assign bus.addr  = addr;
    assign bus.din   = din;
    memory_responder #(
      .AW   (AW),
      .DW   (DW),
      .WAIT (W)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
    assign rdy_w[g]  = bus.rdy;
    assign busy_w[g] = bus.busy;
    assign err_w[g]  = bus.err;
    assign dout_w[g] = bus.dout;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request pulse; waits (bounded) for rdy on the selected instance, then lets
  // every instance drain. With intrude set, a store to 0x030 is pushed while busy.
  task automatic do_req(input logic ld, input logic st, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit intrude, output int lat,
                        output logic [DW-1:0] rd, output logic err_rdy,
                        output logic err_before);
    @(negedge clk);
    load = ld; store = st; addr = a; din = d;
    @(negedge clk);
    load = 1'b0; store = 1'b0;
    lat = 1;
    err_before = 1'b0;
    while (!rdy_w[sel] && lat < 20) begin
      err_before |= err_w[sel];
      if (intrude && lat == 1) begin
        store = 1'b1; addr = 12'h030; din = 16'h9999;
      end else begin
        store = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    store = 1'b0;
    rd      = dout_w[sel];
    err_rdy = err_w[sel];
    @(negedge clk);
    check("rdy_one_cycle", {31'd0, rdy_w[sel]}, 32'd0);
    repeat (12) @(negedge clk);
  endtask

  int            lat;
  logic [DW-1:0] rd;
  logic          erdy, ebefore;
  logic [MW-1:0] tmp;

  initial begin
    checks = 0; errors = 0; sel = 1;
    rst_n = 1'b0; load = 1'b0; store = 1'b0; addr = '0; din = '0;
    repeat (3) @(negedge clk);
    check("reset_dout", {16'd0, dout_w[1]}, 32'd0);
    check("reset_rdy",  {31'd0, rdy_w[1]},  32'd0);
    check("reset_busy", {28'd0, busy_w},    32'd0);
    check("reset_err",  {28'd0, err_w},     32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic store/load, WAIT=1.
    sel = 1;
    do_req(1'b0, 1'b1, 12'h010, 16'h1234, 1'b0, lat, rd, erdy, ebefore);
    check("st010_lat", lat, 32'd3);
    check("st010_err", {31'd0, erdy | ebefore}, 32'd0);
    do_req(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, lat, rd, erdy, ebefore);
    check("ld010_lat", lat, 32'd3);
    check("ld010_dout", {16'd0, rd}, 32'h1234);
    check("ld010_err", {31'd0, erdy | ebefore}, 32'd0);
    // dout holds through a store.
    do_req(1'b0, 1'b1, 12'h011, 16'hAAAA, 1'b0, lat, rd, erdy, ebefore);
    check("dout_hold_store", {16'd0, dout_w[1]}, 32'h1234);

    // Collision: both strobes in IDLE.
    @(negedge clk);
    load = 1'b1; store = 1'b1; addr = 12'h010; din = 16'hDEAD;
    @(negedge clk);
    load = 1'b0; store = 1'b0;
    check("coll_err",  {31'd0, err_w[1]},  32'd1);
    check("coll_busy", {31'd0, busy_w[1]}, 32'd0);
    @(negedge clk);
    check("coll_err_end", {31'd0, err_w[1]}, 32'd0);
    check("coll_busy2",   {31'd0, busy_w[1]}, 32'd0);
    do_req(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, lat, rd, erdy, ebefore);
    check("coll_nochange", {16'd0, rd}, 32'h1234);

    // Store while busy is ignored.
    do_req(1'b0, 1'b1, 12'h020, 16'h2020, 1'b0, lat, rd, erdy, ebefore);
    do_req(1'b0, 1'b1, 12'h030, 16'h3333, 1'b0, lat, rd, erdy, ebefore);
    do_req(1'b1, 1'b0, 12'h020, 16'h0000, 1'b1, lat, rd, erdy, ebefore);
    check("busy_ld020", {16'd0, rd}, 32'h2020);
    check("busy_noerr", {31'd0, erdy | ebefore}, 32'd0);
    do_req(1'b1, 1'b0, 12'h030, 16'h0000, 1'b0, lat, rd, erdy, ebefore);
    check("busy_ignored", {16'd0, rd}, 32'h3333);

    // Top address, WAIT=0 and WAIT=7.
    sel = 3;
    do_req(1'b0, 1'b1, 12'hFFF, 16'hBEEF, 1'b0, lat, rd, erdy, ebefore);
    check("w7_st_lat", lat, 32'd9);
    sel = 0;
    do_req(1'b1, 1'b0, 12'hFFF, 16'h0000, 1'b0, lat, rd, erdy, ebefore);
    check("w0_ld_lat", lat, 32'd2);
    check("w0_ld_dout", {16'd0, rd}, 32'hBEEF);
    sel = 3;
    do_req(1'b1, 1'b0, 12'hFFF, 16'h0000, 1'b0, lat, rd, erdy, ebefore);
    check("w7_ld_lat", lat, 32'd9);
    check("w7_ld_dout", {16'd0, rd}, 32'hBEEF);

    // Reset during ACCESS with WAIT=3 aborts the store.
    sel = 2;
    do_req(1'b0, 1'b1, 12'h040, 16'h4444, 1'b0, lat, rd, erdy, ebefore);
    check("w3_st_lat", lat, 32'd5);
    @(negedge clk);
    store = 1'b1; addr = 12'h040; din = 16'h5555;
    @(negedge clk);
    store = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_pre", {31'd0, busy_w[2]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_dout", {16'd0, dout_w[2]}, 32'd0);
    check("abort_busy", {31'd0, busy_w[2]}, 32'd0);
    check("abort_rdy",  {31'd0, rdy_w[2]},  32'd0);
    check("abort_err",  {31'd0, err_w[2]},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_req(1'b1, 1'b0, 12'h040, 16'h0000, 1'b0, lat, rd, erdy, ebefore);
    check("abort_old_data", {16'd0, rd}, 32'h4444);

    // Corrupt one stored data bit and read it back.
    sel = 1;
    do_req(1'b0, 1'b1, 12'h050, 16'h00FF, 1'b0, lat, rd, erdy, ebefore);
    tmp = g_dut[1].u_dut.u_array.mem[12'h050];
    tmp[3] = ~tmp[3];
    g_dut[1].u_dut.u_array.mem[12'h050] <= tmp;
    @(negedge clk);
    do_req(1'b1, 1'b0, 12'h050, 16'h0000, 1'b0, lat, rd, erdy, ebefore);
    check("par_dout", {16'd0, rd}, 32'h00F7);
    check("par_err_rdy", {31'd0, erdy}, {31'd0, ParOn});
    check("par_err_early", {31'd0, ebefore}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
